imem_backing_ctrl: RTL and testbench

Main-memory backing store and controller on the miss side of the instruction cache. It accepts one single-word read (refill) or write (writeback) request at a time over the cache's memory handshake. It emulates a fixed access latency and returns a one-cycle `mem_req_ready` pulse with read data. Word-addressed synchronous storage; no bursts, no request queueing.

---
 rtl/imem_backing_ctrl_if.sv | 21 ++
 rtl/imem_backing_ctrl.sv | 94 +++++++++
 tb/tb_imem_backing_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imem_backing_ctrl_if.sv
// Memory-side handshake between the instruction cache miss logic and its
// backing store: one single-word read or write request at a time.
interface imem_backing_ctrl_if;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req_ready;
    logic [31:0] mem_req_data;
    logic        mem_req_err;

    modport master (
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
        input  mem_req_ready, mem_req_data, mem_req_err
    );

    modport slave (
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
        output mem_req_ready, mem_req_data, mem_req_err
    );
endinterface

// File: rtl/imem_backing_ctrl.sv
// Backing store for the instruction cache refill/writeback path.
// Word-addressed storage behind a fixed-latency single-request handshake;
// mem_req_ready pulses for one cycle when an access completes.
module imem_backing_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 4
) (
    input logic                clk,
    input logic                rst,
    imem_backing_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if (LATENCY == 0) begin : g_bad_latency
        $fatal(1, "imem_backing_ctrl: LATENCY must be at least 1");
    end

    logic [31:0]           mem [DEPTH] = '{default: '0};
    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  oor;
    logic                  access;
    logic                  unused_byte_off;

    assign idx    = addr_q[ADDR_WIDTH+1:2];
    assign oor    = |addr_q[31:ADDR_WIDTH+2];
    assign access = (state == ST_WAIT) && (cnt == '0);

    // byte offset within a word never affects the access
    assign unused_byte_off = ^addr_q[1:0];

    assign bus.mem_req_ready = (state == ST_RESP);
    assign bus.mem_req_err   = (state == ST_RESP) && err_q;
    assign bus.mem_req_data  = rdata;

    // Request sequencing: accept in IDLE, count down latency, respond once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_req_valid) begin
                        wr_q    <= bus.mem_req_wr;
                        addr_q  <= bus.mem_req_addr;
                        wdata_q <= bus.mem_wr_data;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        err_q <= oor;
                        if (!wr_q) begin
                            rdata <= oor ? '0 : mem[idx];
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array update on the access edge; reset suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!rst && access && wr_q && !oor) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_imem_backing_ctrl.sv
// Scoreboard bench for imem_backing_ctrl: the driver predicts each response
// from a word-array reference model and queues it; a monitor pops and
// compares on every ready pulse, including the pulse timing.
module tb_imem_backing_ctrl;
    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_backing_ctrl_if bus();

    imem_backing_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          asserts = 0;
    int          fails = 0;
    int          txn_id = 0;
    logic [31:0] ref_mem [1024];
    logic [31:0] last_read = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: err must never appear without ready; each ready pops one prediction.
    always @(negedge clk) begin
        exp_t e;
        check("err_implies_ready", 32'(bus.mem_req_err && !bus.mem_req_ready), 32'd0);
        if (bus.mem_req_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("resp_data txn %0d", e.id), bus.mem_req_data, e.data);
                check($sformatf("resp_err txn %0d", e.id), 32'(bus.mem_req_err), 32'(e.err));
                check($sformatf("resp_cycle txn %0d", e.id), cyc, e.cyc);
            end
        end
    end

    // Issue one request; caller is #1 after a posedge with the DUT idle.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit drop, input bit hold);
        exp_t     e;
        logic [AW-1:0] idx;
        bit       oor;
        int       n;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = wr;
        bus.mem_req_addr  = addr;
        bus.mem_wr_data   = wdata;
        @(posedge clk); #1;
        idx   = addr[AW+1:2];
        oor   = (addr[31:AW+2] != '0);
        e.cyc = cyc + LAT;
        e.err = oor;
        e.id  = txn_id++;
        if (wr) begin
            if (!oor) ref_mem[idx] = wdata;
            e.data = last_read;
        end else begin
            e.data    = oor ? 32'h0 : ref_mem[idx];
            last_read = e.data;
        end
        sb.push_back(e);
        if (drop) begin
            bus.mem_req_valid = 1'b0;
            bus.mem_req_wr    = $urandom_range(0, 1) == 1;
            bus.mem_req_addr  = $urandom;
            bus.mem_wr_data   = $urandom;
        end
        n = 0;
        while (!bus.mem_req_ready && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_req_ready) begin
            check($sformatf("ready_timeout txn %0d", e.id), 32'd0, 32'd1);
        end
        if (!hold) bus.mem_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit prev_hold;
        bit drop;
        bit hold;
        logic [31:0] a;
        int n;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_wr    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_wr_data   = '0;

        // reset values
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_ready", 32'(bus.mem_req_ready), 32'd0);
            check("reset_err", 32'(bus.mem_req_err), 32'd0);
            check("reset_data", bus.mem_req_data, 32'd0);
        end
        rst = 1'b0;

        // read of untouched memory, write/read-back, byte offset ignored
        txn(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        txn(1'b0, 32'h13, 32'h0, 1'b0, 1'b0);

        // out of range: write dropped, read returns zero, word 0 untouched
        txn(1'b1, 32'h1000, 32'h1234, 1'b0, 1'b0);
        txn(1'b0, 32'h1000, 32'h0, 1'b0, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // valid held across two transactions: pulses LAT+2 apart
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // reset mid-write, then reset colliding with a valid request
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = 1'b1;
        bus.mem_req_addr  = 32'h20;
        bus.mem_wr_data   = 32'h55;
        @(posedge clk); #1;
        bus.mem_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(bus.mem_req_ready), 32'd0);
        check("midrst_data", bus.mem_req_data, 32'd0);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = 1'b0;
        bus.mem_req_addr  = 32'h10;
        @(posedge clk); #1;
        check("rst_vs_valid_ready", 32'(bus.mem_req_ready), 32'd0);
        rst = 1'b0;
        bus.mem_req_valid = 1'b0;
        last_read = '0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        txn(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

        // valid dropped right after acceptance
        txn(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);

        // randomized mix
        prev_hold = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            drop = ($urandom_range(0, 3) == 0);
            hold = !drop && ($urandom_range(0, 3) == 0);
            if (!prev_hold) begin
                n = $urandom_range(0, 2);
                repeat (n) @(posedge clk);
                if (n != 0) #1;
            end
            txn($urandom_range(0, 1) == 1, a, $urandom, drop, hold);
            prev_hold = hold;
        end
        bus.mem_req_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
